// File: rtl/fb_scheduler.sv
// fb_scheduler: shares one single-port framebuffer RAM between display
// fetches for the blitter (always first) and host pixel writes into the
// back buffer, and flips front/back buffers on blitter vsync.
module fb_scheduler #(
  parameter int C_LED_CHAINS       = 4,
  parameter int C_LED_CHAIN_LENGTH = 4,
  parameter int C_LED_NBANKS       = 16,
  parameter int C_LED_WIDTH        = 32,
  parameter int C_BPC              = 12,
  localparam int XW = $clog2(C_LED_WIDTH * C_LED_CHAIN_LENGTH),
  localparam int YW = $clog2(C_LED_NBANKS),
  localparam int BW = $clog2(C_BPC),
  localparam int AW = 1 + YW + XW,
  localparam int DW = C_LED_CHAINS * 3 * C_BPC
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [XW-1:0]             ctl_cur_x,
  input  logic [YW-1:0]             ctl_cur_y,
  input  logic [BW-1:0]             ctl_cur_bit,
  input  logic                      ctl_vsync,
  output logic [3*C_LED_CHAINS-1:0] led_data,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [AW-1:0]             ram_addr,
  output logic [DW-1:0]             ram_wdata,
  output logic [C_LED_CHAINS-1:0]   ram_wmask,
  input  logic [DW-1:0]             ram_rdata,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [XW-1:0]             wr_x,
  input  logic [YW-1:0]             wr_y,
  input  logic [DW-1:0]             wr_data,
  input  logic [C_LED_CHAINS-1:0]   wr_mask,
  input  logic                      swap_req,
  output logic                      swap_done,
  output logic                      display_buf
);

  localparam int NL = 3 * C_LED_CHAINS;
  localparam int TW = XW + YW + BW;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RD_ISSUE   = 2'd1,
    S_RD_CAPTURE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tag_q, tag_d;
  logic              tag_valid_q, tag_valid_d;
  logic [TW-1:0]     pend_q, pend_d;
  logic              pend_buf_q, pend_buf_d;
  logic              swap_pend_q, swap_pend_d;
  logic              vsync_dly_q, vsync_dly_d;
  logic              display_buf_q, display_buf_d;
  logic              swap_done_q, swap_done_d;
  logic [NL-1:0]     led_data_q, led_data_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  logic [DW-1:0]     ram_wdata_q, ram_wdata_d;
  logic [C_LED_CHAINS-1:0] ram_wmask_q, ram_wmask_d;

  logic [TW-1:0]     cur_tag;
  logic              fetch_needed;
  logic              vsync_rise;
  logic              swap_fire;
  logic [BW-1:0]     pend_bit;
  logic [C_BPC-1:0]  rd_comp [NL];
  logic [NL-1:0]     rd_bits;

  assign cur_tag      = {ctl_cur_x, ctl_cur_y, ctl_cur_bit};
  assign fetch_needed = !tag_valid_q || (cur_tag != tag_q);
  // Host writes only get the RAM when the display has nothing to fetch.
  assign wr_ready     = (state_q == S_IDLE) && !fetch_needed;
  assign vsync_rise   = ctl_vsync && !vsync_dly_q;
  // A request arriving on the edge itself counts as pending.
  assign swap_fire    = vsync_rise && (swap_pend_q || swap_req);
  assign pend_bit     = pend_q[BW-1:0];

  // Pick the current subframe bit out of every colour component of the word.
  for (genvar gi = 0; gi < NL; gi++) begin : g_comp
    assign rd_comp[gi] = ram_rdata[gi*C_BPC +: C_BPC];
    assign rd_bits[gi] = rd_comp[gi][pend_bit];
  end

  // Next-state logic: fetch/write arbitration and buffer swap.
  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    tag_valid_d   = tag_valid_q;
    pend_d        = pend_q;
    pend_buf_d    = pend_buf_q;
    led_data_d    = led_data_q;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    ram_wmask_d   = ram_wmask_q;
    swap_pend_d   = swap_pend_q | swap_req;
    swap_done_d   = 1'b0;
    display_buf_d = display_buf_q;
    vsync_dly_d   = ctl_vsync;

    case (state_q)
      S_IDLE: begin
        if (fetch_needed) begin
          ram_en_d   = 1'b1;
          ram_addr_d = {display_buf_q, ctl_cur_y, ctl_cur_x};
          pend_d     = cur_tag;
          pend_buf_d = display_buf_q;
          state_d    = S_RD_ISSUE;
        end else if (wr_valid) begin
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = {~display_buf_q, wr_y, wr_x};
          ram_wdata_d = wr_data;
          ram_wmask_d = wr_mask;
        end
      end
      S_RD_ISSUE: begin
        state_d = S_RD_CAPTURE;
      end
      S_RD_CAPTURE: begin
        led_data_d = rd_bits;
        tag_d      = pend_q;
        // Data read from the buffer that was just swapped away is stale.
        tag_valid_d = (pend_buf_q == display_buf_q);
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (swap_fire) begin
      display_buf_d = ~display_buf_q;
      swap_pend_d   = 1'b0;
      swap_done_d   = 1'b1;
      tag_valid_d   = 1'b0;
    end
  end

  // State and registered outputs; async active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q       <= S_IDLE;
      tag_q         <= '0;
      tag_valid_q   <= 1'b0;
      pend_q        <= '0;
      pend_buf_q    <= 1'b0;
      swap_pend_q   <= 1'b0;
      vsync_dly_q   <= 1'b0;
      display_buf_q <= 1'b0;
      swap_done_q   <= 1'b0;
      led_data_q    <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_wmask_q   <= '0;
    end else begin
      state_q       <= state_d;
      tag_q         <= tag_d;
      tag_valid_q   <= tag_valid_d;
      pend_q        <= pend_d;
      pend_buf_q    <= pend_buf_d;
      swap_pend_q   <= swap_pend_d;
      vsync_dly_q   <= vsync_dly_d;
      display_buf_q <= display_buf_d;
      swap_done_q   <= swap_done_d;
      led_data_q    <= led_data_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_wmask_q   <= ram_wmask_d;
    end
  end

  assign led_data    = led_data_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_wmask   = ram_wmask_q;
  assign swap_done   = swap_done_q;
  assign display_buf = display_buf_q;

endmodule
